// File: rtl/div_unit.sv
// ---------------------------------------------------------------------------
// div_unit
//
// Multi-cycle restoring integer divider for the DIV/DIVU instructions.
// The execute stage raises start_i with the operands and keeps it high
// (stalling) until ready_o comes back. The unit then holds the registered
// {remainder, quotient} result for as long as start_i stays high. When
// start_i drops, the unit returns to idle.
//
// One trial subtraction is performed per clock, so a normal division takes
// WIDTH cycles. A zero divisor is recognised immediately and finishes in
// two cycles with an all-zero result.
//
// Ports
//   clk          : clock, all state changes on the rising edge
//   rst          : synchronous active-high reset
//   signed_div_i : 1 = two's-complement division, 0 = unsigned
//   opdata1_i    : dividend, sampled together with start_i
//   opdata2_i    : divisor, sampled together with start_i
//   start_i      : request, held high until ready_o is observed
//   annul_i      : abort the operation in flight (flush/exception)
//   result_o     : {remainder, quotient}; the remainder goes to HI and the
//                  quotient goes to LO
//   ready_o      : high while result_o is valid
// ---------------------------------------------------------------------------
module div_unit #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 signed_div_i,
    input  logic [WIDTH-1:0]     opdata1_i,
    input  logic [WIDTH-1:0]     opdata2_i,
    input  logic                 start_i,
    input  logic                 annul_i,
    output logic [2*WIDTH-1:0]   result_o,
    output logic                 ready_o
);

    localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        FREE,
        BYZERO,
        ON,
        END
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   divisor_q, divisor_d;
    logic [WIDTH-1:0]   rem_q, rem_d;
    logic [WIDTH-1:0]   quo_q, quo_d;
    logic               neg_quo_q, neg_quo_d;
    logic               neg_rem_q, neg_rem_d;
    logic [2*WIDTH-1:0] result_q, result_d;
    logic               ready_q, ready_d;

    // Operand magnitudes, used only when a new operation is accepted.
    // The most negative value maps onto itself. Read as unsigned, that is
    // its true magnitude, so MIN / -1 wraps to MIN with no special case.
    logic               op1_neg, op2_neg;
    logic [WIDTH-1:0]   op1_mag, op2_mag;

    // One restoring step. The running remainder is always below the
    // divisor, so the shifted value fits in WIDTH+1 bits. The trial
    // difference also fits in WIDTH+1 bits, and its top bit is the borrow.
    logic [WIDTH:0]     rem_shift;
    logic [WIDTH:0]     trial;
    logic [WIDTH-1:0]   rem_step;
    logic [WIDTH-1:0]   quo_step;
    logic [WIDTH-1:0]   quo_final;
    logic [WIDTH-1:0]   rem_final;

    // Datapath for a single iteration and the sign fix-up of its outcome.
    always_comb begin
        op1_neg   = signed_div_i & opdata1_i[WIDTH-1];
        op2_neg   = signed_div_i & opdata2_i[WIDTH-1];
        op1_mag   = op1_neg ? (~opdata1_i + 1'b1) : opdata1_i;
        op2_mag   = op2_neg ? (~opdata2_i + 1'b1) : opdata2_i;

        rem_shift = {rem_q, quo_q[WIDTH-1]};
        trial     = rem_shift - {1'b0, divisor_q};
        rem_step  = trial[WIDTH] ? rem_shift[WIDTH-1:0] : trial[WIDTH-1:0];
        quo_step  = {quo_q[WIDTH-2:0], ~trial[WIDTH]};

        quo_final = neg_quo_q ? (~quo_step + 1'b1) : quo_step;
        rem_final = neg_rem_q ? (~rem_step + 1'b1) : rem_step;
    end

    // Next-state logic for the control FSM and every register it owns.
    // annul_i is tested first in each busy state, so it overrides both
    // completion and a held start_i.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        divisor_d = divisor_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        result_d  = result_q;
        ready_d   = ready_q;

        unique case (state_q)
            FREE: begin
                if (start_i && !annul_i) begin
                    if (opdata2_i == '0) begin
                        state_d = BYZERO;
                    end else begin
                        state_d   = ON;
                        divisor_d = op2_mag;
                        rem_d     = '0;
                        quo_d     = op1_mag;
                        cnt_d     = '0;
                        neg_quo_d = op1_neg ^ op2_neg;
                        neg_rem_d = op1_neg;
                    end
                end
            end

            BYZERO: begin
                if (annul_i) begin
                    state_d  = FREE;
                    result_d = '0;
                    ready_d  = 1'b0;
                end else begin
                    state_d  = END;
                    result_d = '0;
                    ready_d  = 1'b1;
                end
            end

            ON: begin
                if (annul_i) begin
                    state_d  = FREE;
                    result_d = '0;
                    ready_d  = 1'b0;
                end else begin
                    rem_d = rem_step;
                    quo_d = quo_step;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == LAST_ITER) begin
                        state_d  = END;
                        result_d = {rem_final, quo_final};
                        ready_d  = 1'b1;
                    end
                end
            end

            END: begin
                if (annul_i || !start_i) begin
                    state_d  = FREE;
                    result_d = '0;
                    ready_d  = 1'b0;
                end
            end

            default: begin
                state_d  = FREE;
                result_d = '0;
                ready_d  = 1'b0;
            end
        endcase
    end

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= FREE;
            cnt_q     <= '0;
            divisor_q <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            result_q  <= '0;
            ready_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            divisor_q <= divisor_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            result_q  <= result_d;
            ready_q   <= ready_d;
        end
    end

    assign result_o = result_q;
    assign ready_o  = ready_q;

endmodule

// File: tb/tb_div_unit.sv
// ---------------------------------------------------------------------------
// tb_div_unit
//
// Directed self-checking bench for div_unit. A 32-bit instance covers most
// scenarios. An 8-bit instance covers the narrow build. Inputs change 1ns
// after a rising edge, and outputs are sampled at that same point.
// ---------------------------------------------------------------------------
module tb_div_unit;

    logic        clk;
    logic        rst;
    logic        signed_div;
    logic [31:0] op1;
    logic [31:0] op2;
    logic        start;
    logic        annul;
    logic [63:0] result;
    logic        ready;

    logic        s8_signed_div;
    logic [7:0]  s8_op1;
    logic [7:0]  s8_op2;
    logic        s8_start;
    logic        s8_annul;
    logic [15:0] s8_result;
    logic        s8_ready;

    int total;
    int bad;

    div_unit #(.WIDTH(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .signed_div_i (signed_div),
        .opdata1_i    (op1),
        .opdata2_i    (op2),
        .start_i      (start),
        .annul_i      (annul),
        .result_o     (result),
        .ready_o      (ready)
    );

    div_unit #(.WIDTH(8)) dut8 (
        .clk          (clk),
        .rst          (rst),
        .signed_div_i (s8_signed_div),
        .opdata1_i    (s8_op1),
        .opdata2_i    (s8_op2),
        .start_i      (s8_start),
        .annul_i      (s8_annul),
        .result_o     (s8_result),
        .ready_o      (s8_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Launch a division and wait for ready_o, leaving start_i high.
    // lat counts the edges after the start edge; 60 means the wait timed out.
    // When perturb is set, the operands are scrambled right after they are
    // accepted.
    task automatic run_div(input logic sd, input logic [31:0] a, input logic [31:0] b,
                           input logic perturb, output int lat, output logic [63:0] res);
        signed_div = sd;
        op1        = a;
        op2        = b;
        annul      = 1'b0;
        start      = 1'b1;
        tick();
        if (perturb) begin
            op1        = ~a;
            op2        = 32'd3;
            signed_div = ~sd;
        end
        lat = 0;
        while (ready !== 1'b1 && lat < 60) begin
            tick();
            lat++;
        end
        res = result;
    endtask

    task automatic drop_start();
        start = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        total++;
        if (ready !== 1'b0) begin
            bad++;
            $display("[TB] FAIL reset_ready got=%b want=0", ready);
        end
        total++;
        if (result !== 64'd0) begin
            bad++;
            $display("[TB] FAIL reset_result got=%h want=0", result);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_unsigned();
        int lat;
        logic [63:0] res;
        run_div(1'b0, 32'd100, 32'd7, 1'b0, lat, res);
        total++;
        if (lat !== 32) begin
            bad++;
            $display("[TB] FAIL udiv_latency got=%0d want=32", lat);
        end
        total++;
        if (res !== {32'd2, 32'd14}) begin
            bad++;
            $display("[TB] FAIL udiv_100_7 got=%h want=%h", res, {32'd2, 32'd14});
        end
        drop_start();
        total++;
        if (ready !== 1'b0) begin
            bad++;
            $display("[TB] FAIL udiv_drop_ready got=%b want=0", ready);
        end
        total++;
        if (result !== 64'd0) begin
            bad++;
            $display("[TB] FAIL udiv_drop_result got=%h want=0", result);
        end
    endtask

    task automatic test_signed();
        int lat;
        logic [63:0] res;
        logic [63:0] exp_res [3];
        logic [31:0] a_tab [3];
        logic [31:0] b_tab [3];
        logic        s_tab [3];
        a_tab[0] = 32'hFFFF_FF9C; b_tab[0] = 32'd7;         s_tab[0] = 1'b1;
        exp_res[0] = {32'hFFFF_FFFE, 32'hFFFF_FFF2};
        a_tab[1] = 32'd100;       b_tab[1] = 32'hFFFF_FFF9; s_tab[1] = 1'b1;
        exp_res[1] = {32'd2, 32'hFFFF_FFF2};
        a_tab[2] = 32'hFFFF_FFFF; b_tab[2] = 32'd2;         s_tab[2] = 1'b0;
        exp_res[2] = {32'd1, 32'h7FFF_FFFF};
        for (int i = 0; i < 3; i++) begin
            run_div(s_tab[i], a_tab[i], b_tab[i], 1'b0, lat, res);
            total++;
            if (lat !== 32) begin
                bad++;
                $display("[TB] FAIL sdiv_latency[%0d] got=%0d want=32", i, lat);
            end
            total++;
            if (res !== exp_res[i]) begin
                bad++;
                $display("[TB] FAIL sdiv_result[%0d] got=%h want=%h", i, res, exp_res[i]);
            end
            drop_start();
        end
    endtask

    task automatic test_div_zero();
        int lat;
        logic [63:0] res;
        run_div(1'b0, 32'd5, 32'd0, 1'b0, lat, res);
        total++;
        if (lat !== 1) begin
            bad++;
            $display("[TB] FAIL divzero_latency got=%0d want=1", lat);
        end
        total++;
        if (res !== 64'd0) begin
            bad++;
            $display("[TB] FAIL divzero_result got=%h want=0", res);
        end
        drop_start();
    endtask

    task automatic test_overflow();
        int lat;
        logic [63:0] res;
        run_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, lat, res);
        total++;
        if (res !== {32'd0, 32'h8000_0000}) begin
            bad++;
            $display("[TB] FAIL overflow_result got=%h want=%h", res, {32'd0, 32'h8000_0000});
        end
        drop_start();
    endtask

    task automatic test_annul();
        int lat;
        int ready_seen;
        logic [63:0] res;
        signed_div = 1'b0;
        op1        = 32'd1000;
        op2        = 32'd3;
        start      = 1'b1;
        tick();
        for (int i = 0; i < 9; i++) tick();
        annul = 1'b1;
        start = 1'b0;
        tick();
        annul = 1'b0;
        total++;
        if (ready !== 1'b0 || result !== 64'd0) begin
            bad++;
            $display("[TB] FAIL annul_outputs got=%b/%h want=0/0", ready, result);
        end
        ready_seen = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (ready !== 1'b0) ready_seen++;
        end
        total++;
        if (ready_seen !== 0) begin
            bad++;
            $display("[TB] FAIL annul_no_ready got=%0d want=0", ready_seen);
        end
        run_div(1'b0, 32'd9, 32'd4, 1'b0, lat, res);
        total++;
        if (res !== {32'd1, 32'd2} || lat !== 32) begin
            bad++;
            $display("[TB] FAIL annul_followup got=%h lat=%0d want=%h lat=32", res, lat, {32'd1, 32'd2});
        end
        drop_start();
    endtask

    task automatic test_reset_mid();
        int ready_seen;
        signed_div = 1'b0;
        op1        = 32'd1000;
        op2        = 32'd7;
        start      = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) tick();
        rst = 1'b1;
        tick();
        total++;
        if (ready !== 1'b0 || result !== 64'd0) begin
            bad++;
            $display("[TB] FAIL rst_mid_outputs got=%b/%h want=0/0", ready, result);
        end
        rst   = 1'b0;
        start = 1'b0;
        ready_seen = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (ready !== 1'b0) ready_seen++;
        end
        total++;
        if (ready_seen !== 0) begin
            bad++;
            $display("[TB] FAIL rst_mid_no_ready got=%0d want=0", ready_seen);
        end
    endtask

    task automatic test_hold();
        int lat;
        logic [63:0] res;
        run_div(1'b0, 32'd50, 32'd6, 1'b0, lat, res);
        total++;
        if (res !== {32'd2, 32'd8}) begin
            bad++;
            $display("[TB] FAIL hold_result got=%h want=%h", res, {32'd2, 32'd8});
        end
        op1 = 32'd12345;
        op2 = 32'd0;
        for (int i = 0; i < 5; i++) begin
            tick();
            total++;
            if (ready !== 1'b1 || result !== {32'd2, 32'd8}) begin
                bad++;
                $display("[TB] FAIL hold_cycle[%0d] got=%b/%h want=1/%h", i, ready, result, {32'd2, 32'd8});
            end
        end
        drop_start();
    endtask

    task automatic test_ignore_operands();
        int lat;
        logic [63:0] res;
        run_div(1'b0, 32'd77, 32'd5, 1'b1, lat, res);
        total++;
        if (res !== {32'd2, 32'd15} || lat !== 32) begin
            bad++;
            $display("[TB] FAIL ignore_ops got=%h lat=%0d want=%h lat=32", res, lat, {32'd2, 32'd15});
        end
        drop_start();
    endtask

    task automatic test_width8();
        int lat;
        s8_signed_div = 1'b0;
        s8_op1        = 8'd200;
        s8_op2        = 8'd3;
        s8_start      = 1'b1;
        tick();
        lat = 0;
        while (s8_ready !== 1'b1 && lat < 60) begin
            tick();
            lat++;
        end
        total++;
        if (lat !== 8) begin
            bad++;
            $display("[TB] FAIL w8_latency got=%0d want=8", lat);
        end
        total++;
        if (s8_result !== {8'd2, 8'd66}) begin
            bad++;
            $display("[TB] FAIL w8_result got=%h want=%h", s8_result, {8'd2, 8'd66});
        end
        s8_start = 1'b0;
        tick();
        total++;
        if (s8_ready !== 1'b0) begin
            bad++;
            $display("[TB] FAIL w8_drop_ready got=%b want=0", s8_ready);
        end
    endtask

    initial begin
        total         = 0;
        bad           = 0;
        rst           = 1'b1;
        signed_div    = 1'b0;
        op1           = '0;
        op2           = '0;
        start         = 1'b0;
        annul         = 1'b0;
        s8_signed_div = 1'b0;
        s8_op1        = '0;
        s8_op2        = '0;
        s8_start      = 1'b0;
        s8_annul      = 1'b0;

        test_reset();
        test_unsigned();
        test_signed();
        test_div_zero();
        test_overflow();
        test_annul();
        test_reset_mid();
        test_hold();
        test_ignore_operands();
        test_width8();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
